doppler_sequencer: RTL
======================

DOPPLER_SEQUENCER -- requirements
Module: doppler_sequencer

Interface
REQ-001 The block SHALL have parameter BURST_CYCLES, default 400, giving the number of cycles transmit_out is high per measurement.
REQ-002 The block SHALL have parameter GUARD_CYCLES, default 1000, giving the dead cycles between burst end and capture start.
REQ-003 The block SHALL have parameter NUM_SAMPLES, default 2048, giving the number of receiver samples forwarded per measurement.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the maximum cycles to wait for a result.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset: clk_in (input, 1) is the system clock and rst_in (input, 1) is the reset.
REQ-006 Ports SHALL be:
- start_in (input, 1): measurement request.
- abort_in (input, 1): synchronous abort.
- adc_valid_in (input, 1): receiver sample strobe.
- adc_data_in (input, 16): receiver sample.
- doppler_ready_in (input, 1): result strobe from the velocity datapath.
- velocity_in (input, 16): velocity from the velocity datapath.
- towards_in (input, 1): direction from the velocity datapath.
- transmit_out (output, 1): emitter enable.
- sample_valid_out (output, 1): sample strobe to the velocity datapath.
- sample_out (output, 16): sample to the velocity datapath.
- result_valid_out (output, 1): result strobe.
- velocity_out (output, 16): latched velocity.
- towards_out (output, 1): latched direction.
- timeout_out (output, 1): timeout strobe.
- busy_out (output, 1): measurement in progress.

Function
REQ-007 The FSM SHALL have states IDLE, TX, GUARD, CAPTURE and WAIT, with one shared cycle counter and one sample counter sized for its parameter.
REQ-008 In IDLE, start_in=1 SHALL move the FSM to TX on the next edge and clear both counters; start_in SHALL be ignored in every other state.
REQ-009 All outputs SHALL be registered; when start_in is sampled high at edge N, transmit_out SHALL be high for exactly BURST_CYCLES cycles starting after edge N.
REQ-010 TX SHALL go to GUARD after BURST_CYCLES cycles, and GUARD SHALL go to CAPTURE after GUARD_CYCLES cycles; GUARD_CYCLES=0 SHALL go directly from TX to CAPTURE.
REQ-011 In CAPTURE, each cycle with adc_valid_in=1 SHALL produce sample_valid_out=1 and sample_out=adc_data_in one cycle later (1-cycle latency), and SHALL increment the sample counter.
REQ-012 adc_valid_in SHALL be ignored outside CAPTURE, and sample_valid_out SHALL be 0 outside forwarded cycles.
REQ-013 After the NUM_SAMPLES-th forwarded sample the FSM SHALL enter WAIT; no sample beyond NUM_SAMPLES SHALL be forwarded, even when adc_valid_in stays high.
REQ-014 In WAIT, doppler_ready_in=1 SHALL, on the next edge:
- latch velocity_in into velocity_out and towards_in into towards_out;
- pulse result_valid_out for one cycle;
- return the FSM to IDLE.
REQ-015 In WAIT, if TIMEOUT_CYCLES cycles elapse without doppler_ready_in, timeout_out SHALL pulse for one cycle and the FSM SHALL return to IDLE, with velocity_out and towards_out unchanged.
REQ-016 When doppler_ready_in and timeout expiry fall in the same cycle, the result SHALL win: result_valid_out=1 and timeout_out=0.
REQ-017 doppler_ready_in outside WAIT SHALL be ignored and SHALL NOT change velocity_out or towards_out.
REQ-018 abort_in=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge, force transmit_out and sample_valid_out low from that edge, and produce no result or timeout pulse.
REQ-019 abort_in SHALL take priority over start_in, doppler_ready_in and timeout in the same cycle.
REQ-020 busy_out SHALL be 1 in every state except IDLE.
REQ-021 velocity_out and towards_out SHALL hold their last latched values until the next accepted result.

Reset
REQ-022 While rst_in is high, the FSM SHALL be in IDLE, both counters zero and all outputs 0, asynchronously and independent of clk_in.
REQ-023 Reset asserted mid-measurement SHALL drop transmit_out and sample_valid_out immediately, and SHALL NOT produce result_valid_out or timeout_out after release.
REQ-024 After rst_in deasserts, the block SHALL wait in IDLE for start_in.

Verification
REQ-025 The bench SHALL use parameters BURST_CYCLES=4, GUARD_CYCLES=3, NUM_SAMPLES=8, TIMEOUT_CYCLES=20 and cover these directed scenarios:
- Nominal: start pulse at cycle 0, adc_valid_in held high, doppler_ready_in with velocity_in=16'h0123 and towards_in=1 five cycles after WAIT entry -> transmit_out high for 4 cycles, 8 samples forwarded, result_valid_out one cycle, velocity_out=16'h0123, towards_out=1, busy_out falls.
- Timeout: nominal sequence with no doppler_ready_in -> timeout_out single pulse 20 cycles after WAIT entry, velocity_out unchanged, busy_out=0.
- Sample overrun and gating: adc_valid_in high during TX, GUARD and 12 CAPTURE cycles -> exactly 8 sample_valid_out pulses, each carrying the prior-cycle adc_data_in.
- Priority: doppler_ready_in on the 20th WAIT cycle -> result_valid_out=1, timeout_out=0; separately, abort_in together with doppler_ready_in -> neither pulse, FSM in IDLE.
- Ignored inputs: start_in during CAPTURE and doppler_ready_in in IDLE with velocity_in=16'hFFFF -> no restart, velocity_out unchanged.
- Async reset mid-TX: rst_in raised between clock edges -> transmit_out and busy_out low before the next edge, and no pulses after release.

Source files
------------

// File: rtl/doppler_sequencer.sv
// Measurement sequencer for a Doppler front end: it fires a transmit burst, waits out a guard gap,
// forwards a fixed number of receiver samples, then waits (bounded) for the velocity result.
module doppler_sequencer #(
  parameter int BURST_CYCLES   = 400,
  parameter int GUARD_CYCLES   = 1000,
  parameter int NUM_SAMPLES    = 2048,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        abort_in,
  input  logic        adc_valid_in,
  input  logic [15:0] adc_data_in,
  input  logic        doppler_ready_in,
  input  logic [15:0] velocity_in,
  input  logic        towards_in,
  output logic        transmit_out,
  output logic        sample_valid_out,
  output logic [15:0] sample_out,
  output logic        result_valid_out,
  output logic [15:0] velocity_out,
  output logic        towards_out,
  output logic        timeout_out,
  output logic        busy_out
);

  // The shared cycle counter must reach the longest of the three timed phases.
  localparam int CYC_MAX0 = (BURST_CYCLES > GUARD_CYCLES) ? BURST_CYCLES : GUARD_CYCLES;
  localparam int CYC_MAX  = (CYC_MAX0 > TIMEOUT_CYCLES) ? CYC_MAX0 : TIMEOUT_CYCLES;
  localparam int CW       = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int SW       = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

  localparam logic [CW-1:0] BURST_LAST   = CW'(BURST_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LAST   = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SAMPLE_LAST  = SW'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {IDLE, TX, GUARD, CAPTURE, WAIT} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cyc_reg, cyc_next;
  logic [SW-1:0] smp_reg, smp_next;
  logic          transmit_reg, transmit_next;
  logic          sample_valid_reg, sample_valid_next;
  logic [15:0]   sample_reg, sample_next;
  logic          result_valid_reg, result_valid_next;
  logic [15:0]   velocity_reg, velocity_next;
  logic          towards_reg, towards_next;
  logic          timeout_reg, timeout_next;
  logic          busy_reg, busy_next;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg        <= IDLE;
      cyc_reg          <= '0;
      smp_reg          <= '0;
      transmit_reg     <= 1'b0;
      sample_valid_reg <= 1'b0;
      sample_reg       <= '0;
      result_valid_reg <= 1'b0;
      velocity_reg     <= '0;
      towards_reg      <= 1'b0;
      timeout_reg      <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cyc_reg          <= cyc_next;
      smp_reg          <= smp_next;
      transmit_reg     <= transmit_next;
      sample_valid_reg <= sample_valid_next;
      sample_reg       <= sample_next;
      result_valid_reg <= result_valid_next;
      velocity_reg     <= velocity_next;
      towards_reg      <= towards_next;
      timeout_reg      <= timeout_next;
      busy_reg         <= busy_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    cyc_next          = cyc_reg + CW'(1);
    smp_next          = smp_reg;
    transmit_next     = 1'b0;
    sample_valid_next = 1'b0;
    sample_next       = sample_reg;
    result_valid_next = 1'b0;
    velocity_next     = velocity_reg;
    towards_next      = towards_reg;
    timeout_next      = 1'b0;
    busy_next         = 1'b0;

    case (state_reg)
      IDLE: begin
        cyc_next = cyc_reg;
        if (start_in) begin
          state_next = TX;
          cyc_next   = '0;
          smp_next   = '0;
        end
      end
      TX: begin
        if (cyc_reg == BURST_LAST) begin
          cyc_next   = '0;
          state_next = (GUARD_CYCLES == 0) ? CAPTURE : GUARD;
        end
      end
      GUARD: begin
        if (cyc_reg == GUARD_LAST) begin
          cyc_next   = '0;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        cyc_next = cyc_reg;
        if (adc_valid_in) begin
          sample_valid_next = 1'b1;
          sample_next       = adc_data_in;
          if (smp_reg == SAMPLE_LAST) begin
            state_next = WAIT;
            cyc_next   = '0;
          end else begin
            smp_next = smp_reg + SW'(1);
          end
        end
      end
      WAIT: begin
        // A result arriving on the last timeout cycle still counts as a result.
        if (doppler_ready_in) begin
          velocity_next     = velocity_in;
          towards_next      = towards_in;
          result_valid_next = 1'b1;
          state_next        = IDLE;
          cyc_next          = '0;
        end else if (cyc_reg == TIMEOUT_LAST) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
          cyc_next     = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cyc_next   = '0;
      end
    endcase

    if (abort_in && state_reg != IDLE) begin
      state_next        = IDLE;
      cyc_next          = '0;
      sample_valid_next = 1'b0;
      sample_next       = sample_reg;
      result_valid_next = 1'b0;
      velocity_next     = velocity_reg;
      towards_next      = towards_reg;
      timeout_next      = 1'b0;
    end

    transmit_next = (state_next == TX);
    busy_next     = (state_next != IDLE);
  end

  assign transmit_out     = transmit_reg;
  assign sample_valid_out = sample_valid_reg;
  assign sample_out       = sample_reg;
  assign result_valid_out = result_valid_reg;
  assign velocity_out     = velocity_reg;
  assign towards_out      = towards_reg;
  assign timeout_out      = timeout_reg;
  assign busy_out         = busy_reg;

endmodule
